// File: rtl/ots_pkg.sv
// Shared types and sizing helpers for the one-time setup sequencer.
package ots_pkg;

  typedef enum logic [2:0] {
    WAIT_PWR,
    LOAD,
    SHIFT,
    CS_HOLD,
    GAP,
    DONE
  } state_t;

  // Bits needed for a counter that runs 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/ots_spi_shifter.sv
// SCLK divider and MSB-first shift register for one configuration word.
// With OTS_READBACK_EN defined, SDI is captured on every SCLK rising edge.
module ots_spi_shifter
  import ots_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
`ifdef OTS_READBACK_EN
  input  logic              sdi,
  output logic [DATA_W-1:0] rx_word,
  output logic              rx_err_c,
`endif
  output logic              sclk,
  output logic              sdo,
  output logic              fin_c
);

  localparam int unsigned DIV_W = cnt_w(CLK_DIV);
  localparam int unsigned BIT_W = cnt_w(DATA_W);

  logic [DATA_W-1:0] sr;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              active;
  logic              edge_c;

  assign edge_c = active && (div_cnt == DIV_W'(CLK_DIV - 1));
  // The last falling edge ends the word; the FSM leaves SHIFT on this cycle.
  assign fin_c  = edge_c && sclk && (bit_cnt == BIT_W'(DATA_W - 1));
  assign sdo    = sr[DATA_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sr      <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      active  <= 1'b0;
      sclk    <= 1'b0;
    end else if (load) begin
      sr      <= word;
      div_cnt <= '0;
      bit_cnt <= '0;
      active  <= 1'b1;
      sclk    <= 1'b0;
    end else if (active) begin
      if (edge_c) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
        // Shift on the falling edge so SDO is stable around the rising edge.
        if (sclk) begin
          sr      <= {sr[DATA_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + BIT_W'(1);
          if (fin_c) active <= 1'b0;
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

`ifdef OTS_READBACK_EN
  logic [DATA_W-1:0] rx;
  logic [DATA_W-1:0] tx_q;

  assign rx_word  = rx;
  assign rx_err_c = (rx != tx_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx   <= '0;
      tx_q <= '0;
    end else if (load) begin
      rx   <= '0;
      tx_q <= word;
    end else if (edge_c && !sclk) begin
      rx <= {rx[DATA_W-2:0], sdi};
    end
  end
`endif

endmodule

// File: rtl/one_time_setup_seq.sv
// Power-up configuration sequencer: after a settle delay, writes one word to each
// enabled serial slave in turn. Optional readback path enabled by OTS_READBACK_EN.
module one_time_setup_seq
  import ots_pkg::*;
#(
  parameter int unsigned NUM_CS    = 7,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned GAP_CYC   = 8,
  parameter int unsigned START_DLY = 64
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic [NUM_CS-1:0]        ch_en,
  input  logic [NUM_CS*DATA_W-1:0] cfg_data,
`ifdef OTS_READBACK_EN
  input  logic                     SDI,
  output logic [NUM_CS*DATA_W-1:0] rb_data,
  output logic [NUM_CS-1:0]        rb_err,
`endif
  output logic [NUM_CS:1]          CS,
  output logic                     SCLK,
  output logic                     SDO,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned IDX_W   = cnt_w(NUM_CS);
  localparam int unsigned MAX_AB  = (START_DLY > GAP_CYC) ? START_DLY : GAP_CYC;
  localparam int unsigned CNT_MAX = (MAX_AB > CLK_DIV) ? MAX_AB : CLK_DIV;
  localparam int unsigned CNT_W   = cnt_w(CNT_MAX);

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [NUM_CS:1]  cs_n;
  logic             load_c;
  logic             fin_c;
  logic             last_c;

  assign last_c = (idx == IDX_W'(NUM_CS - 1));

`ifdef OTS_READBACK_EN
  logic [DATA_W-1:0] rx_word;
  logic              rx_err_c;
`endif

  ots_spi_shifter #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk      (CLK),
    .rst      (RST),
    .load     (load_c),
    .word     (cfg_data[idx*DATA_W +: DATA_W]),
`ifdef OTS_READBACK_EN
    .sdi      (SDI),
    .rx_word  (rx_word),
    .rx_err_c (rx_err_c),
`endif
    .sclk     (SCLK),
    .sdo      (SDO),
    .fin_c    (fin_c)
  );

  // State, index, counter and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= WAIT_PWR;
      idx   <= '0;
      cnt   <= '0;
      CS    <= '1;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      CS    <= cs_n;
      busy  <= (state_n != DONE);
      done  <= (state_n == DONE);
    end
  end

  // Next-state logic; one shared counter serves the settle, hold and gap phases.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt + CNT_W'(1);
    cs_n    = CS;
    load_c  = 1'b0;
    case (state)
      WAIT_PWR: begin
        if (cnt == CNT_W'(START_DLY - 1)) begin
          cnt_n   = '0;
          state_n = LOAD;
        end
      end
      LOAD: begin
        cnt_n = '0;
        if (ch_en[idx]) begin
          load_c  = 1'b1;
          cs_n    = ~(NUM_CS'(1) << idx);
          state_n = SHIFT;
        end else if (last_c) begin
          state_n = DONE;
        end else begin
          idx_n = idx + IDX_W'(1);
        end
      end
      SHIFT: begin
        cnt_n = '0;
        if (fin_c) state_n = CS_HOLD;
      end
      CS_HOLD: begin
        if (cnt == CNT_W'(CLK_DIV - 1)) begin
          cnt_n   = '0;
          cs_n    = '1;
          state_n = GAP;
        end
      end
      GAP: begin
        if (cnt == CNT_W'(GAP_CYC - 1)) begin
          cnt_n = '0;
          if (last_c) begin
            state_n = DONE;
          end else begin
            idx_n   = idx + IDX_W'(1);
            state_n = LOAD;
          end
        end
      end
      DONE: begin
        cnt_n = '0;
        if (start) begin
          idx_n   = '0;
          state_n = LOAD;
        end
      end
      default: begin
        cnt_n   = '0;
        idx_n   = '0;
        cs_n    = '1;
        state_n = WAIT_PWR;
      end
    endcase
  end

`ifdef OTS_READBACK_EN
  // Captured word is filed when the slave's last bit has been clocked.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rb_data <= '0;
      rb_err  <= '0;
    end else begin
      if (state == DONE && start) rb_err <= '0;
      if (state == SHIFT && fin_c) begin
        rb_data[idx*DATA_W +: DATA_W] <= rx_word;
        rb_err[idx]                   <= rx_err_c;
      end
    end
  end
`endif

endmodule

// File: tb/tb_one_time_setup_seq.sv
// Directed bench for one_time_setup_seq with an SDO-bit scoreboard.
module tb_one_time_setup_seq;

  localparam int unsigned NUM_CS = 7;
  localparam int unsigned DATA_W = 16;

  logic                     CLK = 1'b0;
  logic                     RST;
  logic                     start;
  logic [NUM_CS-1:0]        ch_en;
  logic [NUM_CS*DATA_W-1:0] cfg_data;
  logic [NUM_CS:1]          CS;
  logic                     SCLK;
  logic                     SDO;
  logic                     busy;
  logic                     done;
`ifdef OTS_READBACK_EN
  logic                     SDI;
  logic [NUM_CS*DATA_W-1:0] rb_data;
  logic [NUM_CS-1:0]        rb_err;
  // Loopback, except slave 4 answers all zeros.
  assign SDI = (CS[4] == 1'b0) ? 1'b0 : SDO;
`endif

  one_time_setup_seq dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .ch_en    (ch_en),
    .cfg_data (cfg_data),
`ifdef OTS_READBACK_EN
    .SDI      (SDI),
    .rb_data  (rb_data),
    .rb_err   (rb_err),
`endif
    .CS       (CS),
    .SCLK     (SCLK),
    .SDO      (SDO),
    .busy     (busy),
    .done     (done)
  );

  always #5 CLK = ~CLK;

  int   checks = 0;
  int   failures = 0;
  logic exp_q[$];
  int   t_fall[0:NUM_CS];
  int   t_rise[0:NUM_CS];
  int   t_done, n_rise, rise_cs1, n_extra, n_tog, n_multi, n_hi_tog;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    for (int b = DATA_W - 1; b >= 0; b--) exp_q.push_back(w[b]);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cs"}, 128'(CS), 128'(7'h7F));
    check({tag, "_sclk"}, 128'(SCLK), 0);
    check({tag, "_sdo"}, 128'(SDO), 0);
    check({tag, "_busy"}, 128'(busy), 1);
    check({tag, "_done"}, 128'(done), 0);
  endtask

  // Cycle 0 is the current cycle; records bus events until done or budget.
  task automatic run_seq(input int budget, input int start_at);
    logic [NUM_CS:1] pcs;
    logic            ps;
    logic            e;
    for (int i = 0; i <= NUM_CS; i++) begin
      t_fall[i] = -1;
      t_rise[i] = -1;
    end
    t_done = -1; n_rise = 0; rise_cs1 = 0; n_extra = 0;
    n_tog = 0; n_multi = 0; n_hi_tog = 0;
    pcs = CS;
    ps  = SCLK;
    for (int c = 0; c < budget; c++) begin
      if (!ps && SCLK) begin
        n_rise++;
        if (!CS[1]) rise_cs1++;
        if (exp_q.size() == 0) n_extra++;
        else begin
          e = exp_q.pop_front();
          check("sdo_bit", 128'(SDO), 128'(e));
        end
      end
      if (CS != pcs || SCLK != ps) n_tog++;
      if (CS != pcs && (SCLK || ps)) n_hi_tog++;
      if ($countones(~CS) > 1) n_multi++;
      for (int k = 1; k <= NUM_CS; k++) begin
        if (pcs[k] && !CS[k] && t_fall[k] < 0) t_fall[k] = c;
        if (!pcs[k] && CS[k] && t_rise[k] < 0) t_rise[k] = c;
      end
      if (done) begin
        t_done = c;
        break;
      end
      start = (c == start_at);
      pcs = CS;
      ps  = SCLK;
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    int n;
    int nr;
    logic ps;
    logic [NUM_CS*DATA_W-1:0] exp_rb;

    RST = 1'b1;
    start = 1'b0;
    ch_en = 7'h7F;
    for (int i = 0; i < 7; i++) cfg_data[i*DATA_W +: DATA_W] = 16'hA500 + 16'(i);
    tick();
    tick();
    check_reset_vals("rst");
`ifdef OTS_READBACK_EN
    check("rst_rb_data", 128'(rb_data), 0);
    check("rst_rb_err", 128'(rb_err), 0);
`endif

    // All slaves; a start pulse while busy must be ignored.
    for (int w = 0; w < 7; w++) push_word(16'hA500 + 16'(w));
    RST = 1'b0;
    run_seq(1200, 300);
    check("all_cs1_fall", 128'(t_fall[1]), 65);
    check("all_rises_cs1", 128'(rise_cs1), 16);
    check("all_cs1_low_len", 128'(t_rise[1] - t_fall[1]), 132);
    check("all_cs2_after", 128'(t_fall[2] - t_rise[1]), 9);
    check("all_done_cycle", 128'(t_done), 1051);
    check("all_busy_done", 128'(busy), 0);
    check("all_rises_total", 128'(n_rise), 112);
    check("all_sb_left", 128'(exp_q.size()), 0);
    check("all_extra_rise", 128'(n_extra), 0);
    check("all_multi_cs", 128'(n_multi), 0);
    check("all_cs_tog_sclk_hi", 128'(n_hi_tog), 0);
`ifdef OTS_READBACK_EN
    exp_rb = cfg_data;
    exp_rb[3*DATA_W +: DATA_W] = '0;
    check("rb_data", 128'(rb_data), 128'(exp_rb));
    check("rb_err", 128'(rb_err), 128'(7'b0001000));
`endif

    // Restart from DONE: no settle delay.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_done_low", 128'(done), 0);
    check("restart_busy", 128'(busy), 1);
`ifdef OTS_READBACK_EN
    check("restart_rb_err_clr", 128'(rb_err), 0);
`endif
    n = -1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (!CS[1]) begin
        n = i;
        break;
      end
    end
    check("restart_cs1_lat", 128'(n), 1);

    // Reset after the 5th SCLK rise aborts the word.
    nr = 0;
    ps = SCLK;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!ps && SCLK) nr++;
      ps = SCLK;
      if (nr == 5) break;
    end
    check("abort_rises", 128'(nr), 5);
    check("abort_sclk_hi", 128'(SCLK), 1);
    RST = 1'b1;
    ch_en = 7'b0000101;
    tick();
    check_reset_vals("abort");
`ifdef OTS_READBACK_EN
    check("abort_rb_err", 128'(rb_err), 0);
`endif

    // Sparse enables after the abort: full settle delay again.
    exp_q.delete();
    push_word(16'hA500);
    push_word(16'hA502);
    RST = 1'b0;
    run_seq(600, -1);
    check("sparse_cs1_fall", 128'(t_fall[1]), 65);
    check("sparse_cs3_gap", 128'(t_fall[3] - t_rise[1]), 10);
    check("sparse_cs2_idle", 128'(t_fall[2]), 128'(-1));
    check("sparse_done_cycle", 128'(t_done), 351);
    check("sparse_sb_left", 128'(exp_q.size()), 0);
    check("sparse_extra_rise", 128'(n_extra), 0);

    // Nothing enabled: no bus activity at all.
    RST = 1'b1;
    ch_en = '0;
    tick();
    exp_q.delete();
    RST = 1'b0;
    run_seq(200, -1);
    check("none_done_cycle", 128'(t_done), 71);
    check("none_toggles", 128'(n_tog), 0);
    check("none_rises", 128'(n_rise), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
